fp_round_pack: RTL and testbench

- Final stage of the FP subtract datapath; sits directly downstream of the normaliser.
- Takes a normalised sign/exponent/24-bit mantissa plus guard/round/sticky bits.
- Applies IEEE-754 round-to-nearest-even and renormalises on mantissa carry-out.
- Packs the 32-bit single-precision word with exception flags, through a 2-stage valid/ready pipeline.

---
 rtl/fp_round_pack.sv | 121 ++++++++++++
 tb/tb_fp_round_pack.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and IEEE-754 single-precision pack stage, 2-deep valid/ready pipeline.
// Define FP_FTZ_EN to flush denormal results to signed zero.
module fp_round_pack #(
    parameter int          PIPE_STAGES  = 2,
    parameter logic [31:0] QNAN_PATTERN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [23:0] in_man,
    input  logic [2:0]  in_grs,
    input  logic [1:0]  in_special,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_INF  = 2'b01;
    localparam logic [1:0] CLS_NAN  = 2'b10;

    generate
        if (PIPE_STAGES != 2) begin : g_bad_depth
            $error("fp_round_pack supports PIPE_STAGES == 2 only");
        end
    endgenerate

    // Returns {inexact, exp_r[8:0], man_r[23:0]}
    function automatic logic [33:0] round_rne(input logic [7:0] exp_in,
                                              input logic [23:0] man,
                                              input logic [2:0] grs);
        logic        round_up;
        logic [24:0] sum;
        logic [8:0]  exp_r;
        logic [23:0] man_r;
        round_up = grs[2] && (grs[1] || grs[0] || man[0]);
        sum      = {1'b0, man} + {24'd0, round_up};
        if (sum[24]) begin
            man_r = sum[24:1];
            exp_r = {1'b0, exp_in} + 9'd1;
        end else begin
            man_r = sum[23:0];
            exp_r = {1'b0, exp_in};
        end
        return {|grs, exp_r, man_r};
    endfunction

    // Returns {flags[3:0], result[31:0]}; flags = {invalid, overflow, underflow, inexact}
    function automatic logic [35:0] pack(input logic [1:0] cls, input logic sign,
                                         input logic [8:0] exp_r, input logic [23:0] man_r,
                                         input logic inexact);
        logic [31:0] res;
        logic [3:0]  flg;
        res = {sign, 31'd0};
        flg = 4'b0000;
        if (cls == CLS_NAN) begin
            res = QNAN_PATTERN;
            flg = 4'b1000;
        end else if (cls == CLS_INF) begin
            res = {sign, 8'hFF, 23'd0};
        end else if (cls != CLS_NORM || man_r == 24'd0) begin
            res = {sign, 31'd0};
        end else if (exp_r >= 9'd255) begin
            res = {sign, 8'hFF, 23'd0};
            flg = 4'b0101;
        end else if (!man_r[23]) begin
`ifdef FP_FTZ_EN
            res = {sign, 31'd0};
            flg = 4'b0011;
`else
            res = {sign, 8'd0, man_r[22:0]};
            flg = {2'b00, inexact, inexact};
`endif
        end else begin
            res = {sign, exp_r[7:0], man_r[22:0]};
            flg = {3'b000, inexact};
        end
        return {flg, res};
    endfunction

    logic        vld_p1, vld_p2;
    logic        adv_p1, adv_p2;
    logic        sign_p1, inexact_p1;
    logic [8:0]  exp_p1;
    logic [23:0] man_p1;
    logic [1:0]  cls_p1;

    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1;
    assign out_valid = vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 4'd0;
        end else begin
            if (adv_p1) vld_p1 <= in_valid;
            if (adv_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) {out_flags, out_result} <= pack(cls_p1, sign_p1, exp_p1, man_p1, inexact_p1);
            end
        end
    end

    // S1: round stage
    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            {inexact_p1, exp_p1, man_p1} <= round_rne(in_exp, in_man, in_grs);
            sign_p1 <= in_sign;
            cls_p1  <= in_special;
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: directed vectors, backpressure and mid-flight reset.
module tb_fp_round_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [23:0] in_man = '0;
    logic [2:0]  in_grs = '0;
    logic [1:0]  in_special = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [35:0] sb_q[$];

    fp_round_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_grs(in_grs),
        .in_special(in_special), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {28'd0, out_flags, out_result}, 64'hDEAD);
            end else begin
                logic [35:0] e;
                e = sb_q.pop_front();
                chk("result", {32'd0, out_result}, {32'd0, e[31:0]});
                chk("flags", {60'd0, out_flags}, {60'd0, e[35:32]});
            end
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic [2:0] g, input logic [1:0] sp,
                        input logic [31:0] res, input logic [3:0] flg,
                        input bit expect_out, output int hs_cyc);
        bit done;
        done = 0;
        hs_cyc = 0;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m; in_grs = g; in_special = sp;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (expect_out) sb_q.push_back({flg, res});
                hs_cyc = cyc;
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("handshake_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

`ifdef FP_FTZ_EN
    localparam logic [31:0] DEN1_RES = 32'h00000000;
    localparam logic [3:0]  DEN1_FLG = 4'b0011;
    localparam logic [31:0] DEN2_RES = 32'h80000000;
    localparam logic [3:0]  DEN2_FLG = 4'b0011;
`else
    localparam logic [31:0] DEN1_RES = 32'h00400000;
    localparam logic [3:0]  DEN1_FLG = 4'b0011;
    localparam logic [31:0] DEN2_RES = 32'h80000010;
    localparam logic [3:0]  DEN2_FLG = 4'b0000;
`endif

    initial begin
        int hs;
        bit seen;
        int lat;
        logic [31:0] held_res;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        chk("rst_out_flags", {60'd0, out_flags}, 64'd0);
        @(posedge clk); #1;

        // Pass-through and latency
        send(0, 8'd127, 24'h800000, 3'b000, 2'b00, 32'h3F800000, 4'b0000, 1, hs);
        seen = 0; lat = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; lat = cyc - hs; end
        end
        chk("latency", 64'(lat), 64'd2);
        @(posedge clk); #1;

        // Directed vectors, back-to-back
        send(0, 8'd127, 24'h800000, 3'b100, 2'b00, 32'h3F800000, 4'b0001, 1, hs);
        send(0, 8'd127, 24'h800001, 3'b100, 2'b00, 32'h3F800002, 4'b0001, 1, hs);
        send(0, 8'd127, 24'hFFFFFF, 3'b100, 2'b00, 32'h40000000, 4'b0001, 1, hs);
        send(0, 8'd254, 24'hFFFFFF, 3'b110, 2'b00, 32'h7F800000, 4'b0101, 1, hs);
        send(0, 8'd0,   24'h000000, 3'b000, 2'b10, 32'h7FC00000, 4'b1000, 1, hs);
        send(1, 8'd0,   24'h000000, 3'b000, 2'b01, 32'hFF800000, 4'b0000, 1, hs);
        send(1, 8'd0,   24'h000000, 3'b000, 2'b11, 32'h80000000, 4'b0000, 1, hs);
        send(0, 8'd127, 24'h800000, 3'b101, 2'b00, 32'h3F800001, 4'b0001, 1, hs);
        send(1, 8'd130, 24'hA00000, 3'b011, 2'b00, 32'hC1200000, 4'b0001, 1, hs);
        send(0, 8'd50,  24'h000000, 3'b000, 2'b00, 32'h00000000, 4'b0000, 1, hs);
        send(0, 8'd0,   24'h400000, 3'b010, 2'b00, DEN1_RES, DEN1_FLG, 1, hs);
        send(1, 8'd0,   24'h000010, 3'b000, 2'b00, DEN2_RES, DEN2_FLG, 1, hs);
        repeat (4) @(posedge clk); #1;

        // Backpressure: third input must be held off
        out_ready = 1'b0;
        send(0, 8'd128, 24'h800000, 3'b000, 2'b00, 32'h40000000, 4'b0000, 1, hs);
        send(0, 8'd129, 24'h800000, 3'b000, 2'b00, 32'h40800000, 4'b0000, 1, hs);
        in_valid = 1'b1; in_sign = 0; in_exp = 8'd130; in_man = 24'h800000;
        in_grs = 3'b000; in_special = 2'b00;
        @(negedge clk);
        held_res = out_result;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        repeat (3) @(negedge clk);
        chk("stall_in_ready_hold", {63'd0, in_ready}, 64'd0);
        chk("stall_result_stable", {32'd0, out_result}, {32'd0, held_res});
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(0, 8'd130, 24'h800000, 3'b000, 2'b00, 32'h41000000, 4'b0000, 1, hs);
        repeat (5) @(posedge clk); #1;

        // Reset with both stages full: stale entries must vanish
        out_ready = 1'b0;
        send(0, 8'd140, 24'h800000, 3'b000, 2'b00, 32'h0, 4'b0, 0, hs);
        send(0, 8'd141, 24'h800000, 3'b000, 2'b00, 32'h0, 4'b0, 0, hs);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_result", {32'd0, out_result}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        send(1, 8'd127, 24'h800000, 3'b000, 2'b00, 32'hBF800000, 4'b0000, 1, hs);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
